// File: rtl/pattern_serializer.sv
// rtl/pattern_serializer.sv - parallel-to-serial front end for the pattern detectors
// A one-word holding register backs a shift register so words stream without bubbles.
module pattern_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int GAP       = 0
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             data_valid_i,
    output logic             data_ready_o,
    output logic             bit_o,
    output logic             bit_valid_o,
    output logic             busy_o,
    output logic [15:0]      words_sent_o
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] hold_reg;
    logic             hold_full;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    bit_cnt;
    logic [3:0]       gap_cnt;
    logic             load, shift_en, word_done, gap_start, accept;

    assign data_ready_o = !hold_full;
    assign accept       = data_valid_i && !hold_full;
    assign bit_valid_o  = (state == S_SHIFT);
    assign busy_o       = (state != S_IDLE) || hold_full;
    assign bit_o        = bit_valid_o &&
                          ((MSB_FIRST != 0) ? shift_reg[WIDTH-1] : shift_reg[0]);
    assign shifted      = (MSB_FIRST != 0) ? {shift_reg[WIDTH-2:0], 1'b0}
                                           : {1'b0, shift_reg[WIDTH-1:1]};

    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift_en   = 1'b0;
        word_done  = 1'b0;
        gap_start  = 1'b0;
        case (state)
            S_IDLE: begin
                if (hold_full) begin
                    load       = 1'b1;
                    state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shift_en = 1'b1;
                if (bit_cnt == LAST_BIT) begin
                    word_done = 1'b1;
                    if (GAP > 0) begin
                        gap_start  = 1'b1;
                        state_next = S_GAP;
                    end else if (hold_full) begin
                        load = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == 4'd0) begin
                    if (hold_full) begin
                        load       = 1'b1;
                        state_next = S_SHIFT;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            state        <= S_IDLE;
            hold_reg     <= '0;
            hold_full    <= 1'b0;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            gap_cnt      <= 4'd0;
            words_sent_o <= 16'd0;
        end else begin
            state <= state_next;
            // load requires hold_full, so it never coincides with acceptance
            if (load) begin
                shift_reg <= hold_reg;
                hold_full <= 1'b0;
                bit_cnt   <= '0;
            end else begin
                if (shift_en) begin
                    shift_reg <= shifted;
                    bit_cnt   <= bit_cnt + 1'b1;
                end
                if (accept) begin
                    hold_reg  <= data_i;
                    hold_full <= 1'b1;
                end
            end
            if (word_done) begin
                words_sent_o <= words_sent_o + 16'd1;
            end
            if (gap_start) begin
                gap_cnt <= GAP_LAST;
            end else if (state == S_GAP && gap_cnt != 4'd0) begin
                gap_cnt <= gap_cnt - 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_pattern_serializer.sv
// tb/tb_pattern_serializer.sv - directed bench for pattern_serializer
// Three instances cover MSB-first/no-gap, MSB-first/GAP=2 and LSB-first.
module tb_pattern_serializer;
    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  a_data = 8'd0, g_data = 8'd0, l_data = 8'd0;
    logic        a_valid = 1'b0, g_valid = 1'b0, l_valid = 1'b0;
    logic        a_ready, g_ready, l_ready;
    logic        a_bit, g_bit, l_bit;
    logic        a_bv, g_bv, l_bv;
    logic        a_busy, g_busy, l_busy;
    logic [15:0] a_ws, g_ws, l_ws;

    pattern_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP(0)) dut_a (
        .clk_i(clk), .clr_i(clr), .data_i(a_data), .data_valid_i(a_valid),
        .data_ready_o(a_ready), .bit_o(a_bit), .bit_valid_o(a_bv),
        .busy_o(a_busy), .words_sent_o(a_ws));

    pattern_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP(2)) dut_g (
        .clk_i(clk), .clr_i(clr), .data_i(g_data), .data_valid_i(g_valid),
        .data_ready_o(g_ready), .bit_o(g_bit), .bit_valid_o(g_bv),
        .busy_o(g_busy), .words_sent_o(g_ws));

    pattern_serializer #(.WIDTH(8), .MSB_FIRST(0), .GAP(0)) dut_l (
        .clk_i(clk), .clr_i(clr), .data_i(l_data), .data_valid_i(l_valid),
        .data_ready_o(l_ready), .bit_o(l_bit), .bit_valid_o(l_bv),
        .busy_o(l_busy), .words_sent_o(l_ws));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", a_ready); end
        checks++; if (a_bv !== 1'b0) begin failures++; $display("FAIL reset_bit_valid got=%b exp=0", a_bv); end
        checks++; if (a_bit !== 1'b0) begin failures++; $display("FAIL reset_bit got=%b exp=0", a_bit); end
        checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
        checks++; if (a_ws !== 16'd0) begin failures++; $display("FAIL reset_words got=%0d exp=0", a_ws); end
        checks++; if (g_ready !== 1'b1 || l_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_other got=%b%b exp=11", g_ready, l_ready); end
        clr = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [7:0] w = 8'hB0;
        a_data = w; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        checks++; if (a_ready !== 1'b0 || a_bv !== 1'b0) begin failures++; $display("FAIL single_accept ready=%b bv=%b exp ready=0 bv=0", a_ready, a_bv); end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (a_bv !== 1'b1 || a_bit !== w[7-i]) begin
                failures++; $display("FAIL single_bit%0d bv=%b bit=%b exp bv=1 bit=%b", i, a_bv, a_bit, w[7-i]);
            end
        end
        tick();
        checks++; if (a_bv !== 1'b0) begin failures++; $display("FAIL single_end_bv got=%b exp=0", a_bv); end
        checks++; if (a_ws !== 16'd1) begin failures++; $display("FAIL single_words got=%0d exp=1", a_ws); end
        checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL single_busy got=%b exp=0", a_busy); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] s = 16'hBB0B;
        a_data = 8'hBB; a_valid = 1'b1;
        tick();
        a_data = 8'h0B;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 1) begin
                a_valid = 1'b0;
                checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_held got=%b exp=0", a_ready); end
            end
            if (i == 8) begin
                checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_back got=%b exp=1", a_ready); end
            end
            checks++;
            if (a_bv !== 1'b1 || a_bit !== s[15-i]) begin
                failures++; $display("FAIL b2b_bit%0d bv=%b bit=%b exp bv=1 bit=%b", i, a_bv, a_bit, s[15-i]);
            end
        end
        tick();
        checks++; if (a_bv !== 1'b0) begin failures++; $display("FAIL b2b_end_bv got=%b exp=0", a_bv); end
        checks++; if (a_ws !== 16'd3) begin failures++; $display("FAIL b2b_words got=%0d exp=3", a_ws); end
    endtask

    task automatic test_gap();
        logic exp_bv;
        g_data = 8'hFF; g_valid = 1'b1;
        tick();
        for (int i = 0; i < 19; i++) begin
            tick();
            if (i == 1) g_valid = 1'b0;
            exp_bv = (i < 8) || (i >= 10 && i < 18);
            checks++;
            if (g_bv !== exp_bv || g_bit !== exp_bv) begin
                failures++; $display("FAIL gap_cycle%0d bv=%b bit=%b exp bv=%b bit=%b", i, g_bv, g_bit, exp_bv, exp_bv);
            end
        end
        checks++; if (g_ws !== 16'd2) begin failures++; $display("FAIL gap_words got=%0d exp=2", g_ws); end
    endtask

    task automatic test_lsb_first();
        logic [7:0] w = 8'h0D;
        l_data = w; l_valid = 1'b1;
        tick();
        l_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (l_bv !== 1'b1 || l_bit !== w[i]) begin
                failures++; $display("FAIL lsb_bit%0d bv=%b bit=%b exp bv=1 bit=%b", i, l_bv, l_bit, w[i]);
            end
        end
        tick();
        checks++; if (l_bv !== 1'b0 || l_ws !== 16'd1) begin failures++; $display("FAIL lsb_end bv=%b words=%0d exp bv=0 words=1", l_bv, l_ws); end
    endtask

    task automatic test_backpressure();
        logic [7:0] q[$];
        logic [7:0] word = 8'($urandom);
        logic [7:0] acc = 8'd0;
        logic [7:0] exp_w;
        int sent = 0, recv = 0, nb = 0, cyc = 0;
        while (recv < 20 && cyc < 3000) begin
            if (sent < 20) begin
                if (a_ready) begin
                    if ($urandom_range(0, 2) != 0) begin
                        a_data = word; a_valid = 1'b1;
                        q.push_back(word); sent++;
                        word = 8'($urandom);
                    end else begin
                        a_data = 8'($urandom); a_valid = 1'b0;
                    end
                end else begin
                    a_data = 8'($urandom); a_valid = 1'b1;
                end
            end else begin
                a_valid = 1'b0;
            end
            tick();
            cyc++;
            if (a_bv) begin
                acc = {acc[6:0], a_bit};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    recv++;
                    exp_w = (q.size() > 0) ? q.pop_front() : ~acc;
                    checks++;
                    if (acc !== exp_w) begin failures++; $display("FAIL bp_word%0d got=%h exp=%h", recv, acc, exp_w); end
                end
            end
        end
        a_valid = 1'b0;
        checks++; if (recv != 20) begin failures++; $display("FAIL bp_timeout words_seen=%0d exp=20", recv); end
        tick();
        checks++; if (a_ws !== 16'd23) begin failures++; $display("FAIL bp_words got=%0d exp=23", a_ws); end
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] w = 8'hB0;
        a_data = w; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        tick(); tick(); tick();
        #2;
        clr = 1'b1;
        #1;
        checks++; if (a_bv !== 1'b0 || a_bit !== 1'b0) begin failures++; $display("FAIL mid_rst_bv bv=%b bit=%b exp 0 0", a_bv, a_bit); end
        checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", a_busy); end
        checks++; if (a_ws !== 16'd0) begin failures++; $display("FAIL mid_rst_words got=%0d exp=0", a_ws); end
        checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_ready got=%b exp=1", a_ready); end
        tick();
        clr = 1'b0;
        tick();
        a_data = w; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (a_bv !== 1'b1 || a_bit !== w[7-i]) begin
                failures++; $display("FAIL after_rst_bit%0d bv=%b bit=%b exp bv=1 bit=%b", i, a_bv, a_bit, w[7-i]);
            end
        end
        tick();
        checks++; if (a_ws !== 16'd1 || a_bv !== 1'b0) begin failures++; $display("FAIL after_rst_end words=%0d bv=%b exp words=1 bv=0", a_ws, a_bv); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_gap();
        test_lsb_first();
        test_backpressure();
        test_reset_mid_word();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pattern_serializer.md
# pattern_serializer

Parallel-to-serial front end for the pattern detectors. Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on a serial bit/valid pair. The serial pair wires directly to a detector's `input_i`/`valid_i`. A one-word holding register backs a shift register, so consecutive words stream without bubbles unless an inter-word gap is configured.

## Interface
- `WIDTH`, 8 — word width in bits; legal range 2..32.
- `MSB_FIRST`, 1 — 1: bit WIDTH-1 is emitted first; 0: bit 0 is emitted first.
- `GAP`, 0 — idle cycles (`bit_valid_o`=0) inserted after every word; legal range 0..15.

- `clk_i`  input  1  single clock; all flops on the rising edge.
- `clr_i`  input  1  asynchronous, active-high reset.
- `data_i`  input  WIDTH  parallel word.
- `data_valid_i`  input  1  `data_i` is valid.
- `data_ready_o`  output  1  holding register is empty; a word is accepted at a rising edge where `data_valid_i` and `data_ready_o` are both 1.
- `bit_o`  output  1  serial data bit (feeds detector `input_i`).
- `bit_valid_o`  output  1  `bit_o` is valid this cycle (feeds detector `valid_i`).
- `busy_o`  output  1  FSM not IDLE, or holding register full.
- `words_sent_o`  output  16  count of fully emitted words; wraps at 65535 to 0.

## Operation
- Storage:
  - `hold_reg`[WIDTH-1:0] with flag `hold_full`.
  - `shift_reg`[WIDTH-1:0].
  - `bit_cnt` of width clog2(WIDTH).
  - `gap_cnt`[3:0].
- `data_ready_o` = !`hold_full`. It depends only on flops and never on `data_valid_i`.
- On acceptance, `hold_reg` <= `data_i` and `hold_full` <= 1.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE: if `hold_full`, then `shift_reg` <= `hold_reg`, `hold_full` <= 0, `bit_cnt` <= 0, go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: each cycle, shift `shift_reg` toward the output end and increment `bit_cnt`. When `bit_cnt`==WIDTH-1, at that edge:
    - increment `words_sent_o`;
    - if GAP>0, set `gap_cnt` <= GAP-1 and go to GAP;
    - else if `hold_full`, reload `shift_reg` from `hold_reg`, clear `hold_full`, and stay in SHIFT with `bit_cnt` <= 0;
    - else go to IDLE.
  - GAP: decrement `gap_cnt`. When `gap_cnt`==0, reload and go to SHIFT if `hold_full`, else go to IDLE.
- `bit_valid_o` = (state==SHIFT).
- `bit_o` = `shift_reg`[WIDTH-1] when MSB_FIRST, else `shift_reg`[0]. When `bit_valid_o`=0, `bit_o` = 0.
- Simultaneous events:
  - When acceptance and a hold→shift transfer fall on the same edge, the transfer wins. `hold_full` is already 1 in that case, so `data_ready_o`=0 and acceptance cannot occur.
  - Ready returns the cycle after the transfer.
- Upstream must hold `data_i` and `data_valid_i` stable while `data_ready_o`=0. The block ignores `data_i` when not accepting.
- Reset (any time, including mid-word):
  - state = IDLE;
  - `hold_full`, `shift_reg`, `hold_reg`, `bit_cnt`, `gap_cnt`, `words_sent_o` = 0;
  - the partial word and any held word are discarded;
  - outputs are immediately `data_ready_o`=1, `bit_o`=0, `bit_valid_o`=0, `busy_o`=0;
  - operation resumes at the first rising edge after `clr_i` deasserts.

## Timing
- Word accepted at edge N: transfer to the shifter at edge N+1. First bit is driven during cycle N+1→N+2, and the detector samples it at edge N+2.
- Each bit is held exactly one cycle. A word occupies WIDTH consecutive `bit_valid_o`=1 cycles.
- With GAP=0 and the holding register refilled in time, consecutive words produce an unbroken run of `bit_valid_o`=1.
- With GAP=g, exactly g cycles of `bit_valid_o`=0 separate consecutive words.
- `words_sent_o` updates at the edge that ends a word's last bit.
- `data_ready_o` falls at the acceptance edge and rises at the edge that transfers `hold_reg` into `shift_reg`.
- Sustained throughput: one word per WIDTH+GAP cycles. Upstream must present each next word within WIDTH-1 cycles of ready rising to avoid a bubble.

## Test plan
- Single word: WIDTH=8, MSB_FIRST=1, `data_i`=8'hB0 accepted at edge N → `bit_o`=1,0,1,1,0,0,0,0 on cycles N+1..N+8 with `bit_valid_o`=1. `bit_valid_o`=0 at N+9. `words_sent_o`=1.
- Back-to-back, GAP=0: `data_i` 8'hBB then 8'h0B with `data_valid_i` held high → 16 contiguous valid bits 1011101100001011. `data_ready_o` low while `hold_full`=1. `words_sent_o`=2.
- Gap insertion, GAP=2: two words 8'hFF → 8 valid cycles, then exactly 2 cycles of `bit_valid_o`=0, then 8 valid cycles.
- LSB-first, MSB_FIRST=0: `data_i`=8'h0D → `bit_o` sequence 1,0,1,1,0,0,0,0.
- Backpressure: hold `data_valid_i`=1 with a changing `data_i` while `data_ready_o`=0 → only the word present at the accepting edge is serialized. No word is lost or duplicated over 20 random words with random valid gaps.
- Reset mid-word: assert `clr_i` asynchronously after 3 bits of 8'hB0 → `bit_valid_o`, `busy_o`, and `words_sent_o` drop to 0 without waiting for a clock edge. `data_ready_o`=1. The next accepted word emits from its first bit.
